rob_multi: RTL and testbench
============================

# rob_multi

Parametrised reorder buffer for the out-of-order RV32I core. It replaces the fixed-size ROB with these changes:
- depth is set by a parameter;
- there are two writeback ports;
- full/empty flow control is explicit;
- branch and JALR resolution are handled at commit, with a precise flush;
- same-cycle writeback bypass on the operand query ports is optional.

It sits between the decoder/issue stage, the RS and LSB result buses, and the register file.

## Interface
- `IDW`, default 3: entry-id width; DEPTH = 2**IDW.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when 0, all state holds.
- `issue_valid` in 1: decoder presents an instruction.
- `issue_ready` out 1: `count != DEPTH`.
- `issue_id` out IDW: current tail; the id assigned on accept.
- `issue_kind` in 2: 0 REG (writes rd), 1 BRANCH, 2 STORE, 3 JALR (writes rd).
- `issue_rd` in 5: destination register.
- `issue_pc` in 32: instruction address.
- `issue_pred_taken` in 1: BRANCH prediction.
- `issue_done` in 1: value already known (LUI/AUIPC/JAL).
- `issue_value` in 32: value when `issue_done` = 1.
- `wb0_valid`, `wb0_id`[IDW], `wb0_value`[32], `wb0_taken`, `wb0_target`[32], all in: RS/ALU result bus.
- `wb1_valid`, `wb1_id`[IDW], `wb1_value`[32], all in: LSB result bus.
- `commit_valid` out 1: registered one-cycle pulse.
- `commit_id` out IDW: id of the committed entry.
- `commit_rd` out 5: 0 for BRANCH/STORE.
- `commit_value` out 32: committed value.
- `commit_store` out 1: committed entry is a STORE; LSB may write memory.
- `flush` out 1: registered one-cycle pulse.
- `flush_pc` out 32: redirect address.
- `q1_id`, `q2_id` in IDW: operand lookup ids.
- `q1_ready`, `q2_ready` out 1: value available (combinational).
- `q1_value`, `q2_value` out 32: corresponding values.
- `count` out IDW+1: number of occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- **Reset:**
  - head, tail and count are 0.
  - All busy/ready bits are 0.
  - `commit_valid`, `commit_store`, `flush`, `commit_rd`, `commit_value`, `commit_id` and `flush_pc` are 0.
- **Issue:** accepted when `rdy && issue_valid && issue_ready && !flush_now`.
  - The entry at tail becomes busy.
  - ready = `issue_done`; value = `issue_value`.
  - tail advances by 1 modulo DEPTH (natural wrap).
- **Writeback:** `wbX_valid` sets ready and value of entry `wbX_id`.
  - `wb0` also latches taken and target.
  - Writeback to a non-busy entry is ignored.
  - Both ports hitting the same id in one cycle is illegal; `wb1` wins.
- **Commit:** when head is busy and ready, at most one entry per cycle.
  - `commit_*` is registered and head advances.
  - count = count + accepted_issue − commit.
- **Mispredict at commit:**
  - BRANCH with taken != pred: `flush_pc` = taken ? target : pc+4.
  - JALR always redirects: `flush_pc` = target.
  - That entry still commits; JALR writes rd = pc+4, supplied via `issue_value` at issue.
  - `flush` is pulsed and all entries are cleared: head = tail = count = 0, busy = 0.
  - Issue and writebacks in the flush cycle are discarded.
- **Query:**
  - `qN_ready` = busy[id] && ready[id]; `qN_value` = value[id].
  - Otherwise both outputs are 0.

## Timing
- Issue to entry visible: 1 cycle.
- Writeback to query-visible: 1 cycle (0 with bypass).
- Head ready to `commit_valid`: 1 cycle after the edge where ready is set.
- `flush` is asserted in the same registered cycle as the mispredicted commit.
- `rdy` = 0: all registers hold, including the pulse outputs. Consumers act only on `rdy` = 1 edges, so each pulse is consumed exactly once.
- Full: `issue_ready` = 0 even if a commit happens in the same cycle (no pass-through).
- Empty: no commit.
- Issue and commit in the same cycle leave count unchanged.
- `rst` mid-operation overrides everything, including an in-flight flush.

## Configuration
- `ROB_WB_BYPASS_EN` defined:
  - A same-cycle `wb0`/`wb1` hit on a busy `qN_id` drives `qN_ready` = 1 and `qN_value` = the bus value.
  - `wb0` has priority over `wb1`, and both over stored state.
- `ROB_WB_BYPASS_EN` undefined: query reflects stored state only.

## Test plan
- **Reset, full, wrap:** reset, then issue 8 REG with `issue_done` = 0 (IDW = 3) → `count` = 8, `issue_ready` = 0, ids 0..7. Write back id 0 value 0x11 → next cycle `commit_valid`, `commit_rd` as issued, `commit_value` 0x11. Issue once more → id 0 (wrap).
- **Out-of-order writeback:** `wb1` id 2 = 0xAA, then `wb0` id 1 = 0x55, then `wb0` id 0 = 0x33 → commits in order 0, 1, 2 on consecutive cycles with values 0x33, 0x55, 0xAA.
- **Branch mispredict flush:** BRANCH pc 0x100, pred 0, followed by 3 REG; `wb0` taken = 1, target 0x180 → `flush` = 1, `flush_pc` 0x180, then `count` = 0, `empty` = 1; a concurrent issue is dropped.
- **Correct prediction and JALR:** BRANCH taken = pred → no flush. JALR pc 0x200 with target 0x300 → `commit_rd` = rd, value 0x204, `flush_pc` 0x300.
- **Query bypass:** query id 3 while `wb0` writes id 3 = 0xDEAD.
  - With `ROB_WB_BYPASS_EN` → `q1_ready` = 1 and `q1_value` 0xDEAD the same cycle.
  - Without it → ready 0, then 1 the next cycle.
- **rdy stall:** hold `rdy` = 0 for 3 cycles with `issue_valid` and `wb0_valid` active → `count`, head, tail and pulses are unchanged; a pending commit completes exactly once after `rdy` returns to 1.

Source files
------------

// File: rtl/rob_multi.sv
`default_nettype none
// ============================================================================
//  Module   : rob_multi
//  Purpose  : Parametrised reorder buffer for the out-of-order RV32I core.
//             DEPTH = 2**IDW entries, one issue port, two writeback ports
//             (wb0 = RS/ALU bus carrying branch outcome, wb1 = LSB bus),
//             in-order single commit, precise flush on a mispredicted
//             BRANCH or any JALR at commit, two operand query ports.
//  Ports    : clk, rst (sync, active-high), rdy (global enable)
//             issue_*  : decoder handshake, issue_id = current tail
//             wb0_*    : value/taken/target writeback
//             wb1_*    : value writeback
//             commit_* : registered commit pulse and payload
//             flush, flush_pc : registered redirect pulse
//             q1_*/q2_*: operand lookup (combinational)
//             count, empty : occupancy
//  Config   : `ROB_WB_BYPASS_EN -- same-cycle writeback bypass on queries
//  Revision : 1.0 - initial release
// ============================================================================
module rob_multi #(
    parameter int IDW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            issue_valid,
    output logic            issue_ready,
    output logic [IDW-1:0]  issue_id,
    input  logic [1:0]      issue_kind,
    input  logic [4:0]      issue_rd,
    input  logic [31:0]     issue_pc,
    input  logic            issue_pred_taken,
    input  logic            issue_done,
    input  logic [31:0]     issue_value,
    input  logic            wb0_valid,
    input  logic [IDW-1:0]  wb0_id,
    input  logic [31:0]     wb0_value,
    input  logic            wb0_taken,
    input  logic [31:0]     wb0_target,
    input  logic            wb1_valid,
    input  logic [IDW-1:0]  wb1_id,
    input  logic [31:0]     wb1_value,
    output logic            commit_valid,
    output logic [IDW-1:0]  commit_id,
    output logic [4:0]      commit_rd,
    output logic [31:0]     commit_value,
    output logic            commit_store,
    output logic            flush,
    output logic [31:0]     flush_pc,
    input  logic [IDW-1:0]  q1_id,
    input  logic [IDW-1:0]  q2_id,
    output logic            q1_ready,
    output logic [31:0]     q1_value,
    output logic            q2_ready,
    output logic [31:0]     q2_value,
    output logic [IDW:0]    count,
    output logic            empty
);

    localparam int          DEPTH        = 2**IDW;
    localparam logic [IDW:0] c_DEPTH_CNT = (IDW+1)'(DEPTH);

    localparam logic [1:0] c_KIND_REG    = 2'd0;
    localparam logic [1:0] c_KIND_BRANCH = 2'd1;
    localparam logic [1:0] c_KIND_STORE  = 2'd2;
    localparam logic [1:0] c_KIND_JALR   = 2'd3;

    // Entry storage
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_pred;
    logic [DEPTH-1:0] r_taken;
    logic [31:0]      r_value  [DEPTH];
    logic [31:0]      r_pc     [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [4:0]       r_rd     [DEPTH];
    logic [1:0]       r_kind   [DEPTH];

    logic [IDW-1:0]   r_head;
    logic [IDW-1:0]   r_tail;
    logic [IDW:0]     r_count;

    logic             r_commit_valid;
    logic [IDW-1:0]   r_commit_id;
    logic [4:0]       r_commit_rd;
    logic [31:0]      r_commit_value;
    logic             r_commit_store;
    logic             r_flush;
    logic [31:0]      r_flush_pc;

    logic             w_commit;
    logic             w_flush_now;
    logic             w_issue;
    logic [1:0]       w_head_kind;
    logic [31:0]      w_redirect_pc;

    // An empty ROB has no busy entry at head, so commit needs no count test.
    assign w_head_kind = r_kind[r_head];
    assign w_commit    = r_busy[r_head] && r_ready[r_head];

    // JALR always redirects; a BRANCH redirects only on a wrong prediction.
    assign w_flush_now = w_commit &&
                         ((w_head_kind == c_KIND_JALR) ||
                          ((w_head_kind == c_KIND_BRANCH) &&
                           (r_taken[r_head] != r_pred[r_head])));

    assign w_redirect_pc = (w_head_kind == c_KIND_JALR || r_taken[r_head])
                           ? r_target[r_head] : (r_pc[r_head] + 32'd4);

    // No pass-through when full: a commit in the same cycle does not free
    // the slot for this cycle's issue.
    assign issue_ready = (r_count != c_DEPTH_CNT);
    assign issue_id    = r_tail;
    assign w_issue     = rdy && issue_valid && issue_ready && !w_flush_now;

    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign commit_valid = r_commit_valid;
    assign commit_id    = r_commit_id;
    assign commit_rd    = r_commit_rd;
    assign commit_value = r_commit_value;
    assign commit_store = r_commit_store;
    assign flush        = r_flush;
    assign flush_pc     = r_flush_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_busy         <= '0;
            r_ready        <= '0;
            r_pred         <= '0;
            r_taken        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_id    <= '0;
            r_commit_rd    <= 5'd0;
            r_commit_value <= 32'd0;
            r_commit_store <= 1'b0;
            r_flush        <= 1'b0;
            r_flush_pc     <= 32'd0;
        end else if (rdy) begin
            r_commit_valid <= w_commit;
            r_commit_store <= w_commit && (w_head_kind == c_KIND_STORE);
            r_flush        <= w_flush_now;

            if (w_commit) begin
                r_commit_id    <= r_head;
                r_commit_rd    <= ((w_head_kind == c_KIND_BRANCH) ||
                                   (w_head_kind == c_KIND_STORE)) ? 5'd0 : r_rd[r_head];
                r_commit_value <= r_value[r_head];
            end

            if (w_flush_now) begin
                // Precise flush: every younger entry, this cycle's issue and
                // this cycle's writebacks are discarded.
                r_flush_pc <= w_redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_busy     <= '0;
                r_ready    <= '0;
            end else begin
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= issue_done;
                    r_value[r_tail] <= issue_value;
                    r_kind[r_tail]  <= issue_kind;
                    r_rd[r_tail]    <= issue_rd;
                    r_pc[r_tail]    <= issue_pc;
                    r_pred[r_tail]  <= issue_pred_taken;
                    r_taken[r_tail] <= 1'b0;
                end

                if (wb0_valid && r_busy[wb0_id]) begin
                    r_ready[wb0_id]  <= 1'b1;
                    r_taken[wb0_id]  <= wb0_taken;
                    r_target[wb0_id] <= wb0_target;
                    // JALR's rd value (pc+4) arrives at issue; the bus only
                    // supplies its target.
                    if (r_kind[wb0_id] != c_KIND_JALR) begin
                        r_value[wb0_id] <= wb0_value;
                    end
                end

                // Placed after wb0 so wb1 wins an (illegal) same-id collision.
                if (wb1_valid && r_busy[wb1_id]) begin
                    r_ready[wb1_id] <= 1'b1;
                    r_value[wb1_id] <= wb1_value;
                end

                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + IDW'(1);
                end

                r_tail  <= r_tail + IDW'(w_issue);
                r_count <= r_count + (IDW+1)'(w_issue) - (IDW+1)'(w_commit);
            end
        end
    end

    // Operand query ports
    always_comb begin
        q1_ready = 1'b0;
        q1_value = 32'd0;
        q2_ready = 1'b0;
        q2_value = 32'd0;

        if (r_busy[q1_id] && r_ready[q1_id]) begin
            q1_ready = 1'b1;
            q1_value = r_value[q1_id];
        end
        if (r_busy[q2_id] && r_ready[q2_id]) begin
            q2_ready = 1'b1;
            q2_value = r_value[q2_id];
        end

`ifdef ROB_WB_BYPASS_EN
        // wb1 first so wb0 overrides it; both override stored state.
        if (wb1_valid && r_busy[q1_id] && (wb1_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_value = wb1_value;
        end
        if (wb0_valid && r_busy[q1_id] && (wb0_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_value = wb0_value;
        end
        if (wb1_valid && r_busy[q2_id] && (wb1_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_value = wb1_value;
        end
        if (wb0_valid && r_busy[q2_id] && (wb0_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_value = wb0_value;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_multi
//  Purpose  : Directed self-checking bench for rob_multi (IDW = 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rob_multi;

    localparam int IDW = 3;

    logic            clk;
    logic            rst;
    logic            rdy;
    logic            issue_valid;
    logic            issue_ready;
    logic [IDW-1:0]  issue_id;
    logic [1:0]      issue_kind;
    logic [4:0]      issue_rd;
    logic [31:0]     issue_pc;
    logic            issue_pred_taken;
    logic            issue_done;
    logic [31:0]     issue_value;
    logic            wb0_valid;
    logic [IDW-1:0]  wb0_id;
    logic [31:0]     wb0_value;
    logic            wb0_taken;
    logic [31:0]     wb0_target;
    logic            wb1_valid;
    logic [IDW-1:0]  wb1_id;
    logic [31:0]     wb1_value;
    logic            commit_valid;
    logic [IDW-1:0]  commit_id;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_value;
    logic            commit_store;
    logic            flush;
    logic [31:0]     flush_pc;
    logic [IDW-1:0]  q1_id;
    logic [IDW-1:0]  q2_id;
    logic            q1_ready;
    logic [31:0]     q1_value;
    logic            q2_ready;
    logic [31:0]     q2_value;
    logic [IDW:0]    count;
    logic            empty;

    int n_compared;
    int n_mismatched;

    rob_multi #(.IDW(IDW)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_id         (issue_id),
        .issue_kind       (issue_kind),
        .issue_rd         (issue_rd),
        .issue_pc         (issue_pc),
        .issue_pred_taken (issue_pred_taken),
        .issue_done       (issue_done),
        .issue_value      (issue_value),
        .wb0_valid        (wb0_valid),
        .wb0_id           (wb0_id),
        .wb0_value        (wb0_value),
        .wb0_taken        (wb0_taken),
        .wb0_target       (wb0_target),
        .wb1_valid        (wb1_valid),
        .wb1_id           (wb1_id),
        .wb1_value        (wb1_value),
        .commit_valid     (commit_valid),
        .commit_id        (commit_id),
        .commit_rd        (commit_rd),
        .commit_value     (commit_value),
        .commit_store     (commit_store),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .q1_id            (q1_id),
        .q2_id            (q2_id),
        .q1_ready         (q1_ready),
        .q1_value         (q1_value),
        .q2_ready         (q2_ready),
        .q2_value         (q2_value),
        .count            (count),
        .empty            (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_kind = 0; issue_rd = 0; issue_pc = 0;
        issue_pred_taken = 0; issue_done = 0; issue_value = 0;
        wb0_valid = 0; wb0_id = 0; wb0_value = 0; wb0_taken = 0; wb0_target = 0;
        wb1_valid = 0; wb1_id = 0; wb1_value = 0;
        q1_id = 0; q2_id = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred, input logic done, input logic [31:0] val);
        issue_valid = 1; issue_kind = kind; issue_rd = rd; issue_pc = pc;
        issue_pred_taken = pred; issue_done = done; issue_value = val;
        tick();
        issue_valid = 0;
    endtask

    task automatic wb0(input logic [IDW-1:0] id, input logic [31:0] val,
                       input logic tk, input logic [31:0] tgt);
        wb0_valid = 1; wb0_id = id; wb0_value = val; wb0_taken = tk; wb0_target = tgt;
        tick();
        wb0_valid = 0;
    endtask

    task automatic wb1(input logic [IDW-1:0] id, input logic [31:0] val);
        wb1_valid = 1; wb1_id = id; wb1_value = val;
        tick();
        wb1_valid = 0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // ---------------- Reset, full, wrap ----------------
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_issue_ready", 32'(issue_ready), 1);
        check("rst_issue_id", 32'(issue_id), 0);
        check("rst_commit_valid", 32'(commit_valid), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_commit_value", commit_value, 0);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_id%0d", i), 32'(issue_id), 32'(i));
            issue(2'd0, 5'(i + 1), 32'(i * 4), 0, 0, 0);
        end
        check("full_count", 32'(count), 8);
        check("full_issue_ready", 32'(issue_ready), 0);
        check("full_empty", 32'(empty), 0);

        wb0(0, 32'h11, 0, 0);
        check("wb_nocommit_yet", 32'(commit_valid), 0);
        // Commit cycle while full: a concurrent issue must be refused.
        issue(2'd0, 5'd20, 32'h0, 0, 1, 32'h5);
        check("full_commit_valid", 32'(commit_valid), 1);
        check("full_commit_id", 32'(commit_id), 0);
        check("full_commit_rd", 32'(commit_rd), 1);
        check("full_commit_value", commit_value, 32'h11);
        check("full_no_passthru_count", 32'(count), 7);
        check("wrap_issue_id", 32'(issue_id), 0);
        issue(2'd0, 5'd9, 32'h40, 0, 0, 0);
        check("wrap_count", 32'(count), 8);
        check("wrap_commit_pulse_end", 32'(commit_valid), 0);

        // ---------------- Out-of-order writeback ----------------
        do_reset();
        issue(2'd0, 5'd5, 32'h0, 0, 0, 0);
        issue(2'd0, 5'd6, 32'h4, 0, 0, 0);
        issue(2'd0, 5'd7, 32'h8, 0, 0, 0);
        wb1(2, 32'hAA);
        check("ooo_wait_a", 32'(commit_valid), 0);
        wb0(1, 32'h55, 0, 0);
        check("ooo_wait_b", 32'(commit_valid), 0);
        wb0(0, 32'h33, 0, 0);
        check("ooo_wait_c", 32'(commit_valid), 0);
        tick();
        check("ooo_c0_valid", 32'(commit_valid), 1);
        check("ooo_c0_id", 32'(commit_id), 0);
        check("ooo_c0_rd", 32'(commit_rd), 5);
        check("ooo_c0_value", commit_value, 32'h33);
        tick();
        check("ooo_c1_valid", 32'(commit_valid), 1);
        check("ooo_c1_id", 32'(commit_id), 1);
        check("ooo_c1_value", commit_value, 32'h55);
        tick();
        check("ooo_c2_valid", 32'(commit_valid), 1);
        check("ooo_c2_id", 32'(commit_id), 2);
        check("ooo_c2_rd", 32'(commit_rd), 7);
        check("ooo_c2_value", commit_value, 32'hAA);
        tick();
        check("ooo_done_valid", 32'(commit_valid), 0);
        check("ooo_done_empty", 32'(empty), 1);

        // ---------------- Branch mispredict flush ----------------
        do_reset();
        issue(2'd1, 5'd3, 32'h100, 0, 0, 0);
        issue(2'd0, 5'd1, 32'h104, 0, 0, 0);
        issue(2'd0, 5'd2, 32'h108, 0, 0, 0);
        issue(2'd0, 5'd4, 32'h10C, 0, 0, 0);
        check("br_count", 32'(count), 4);
        wb0(0, 32'h0, 1, 32'h180);
        // Flush cycle: issue and writeback alongside must be dropped.
        wb1_valid = 1; wb1_id = 1; wb1_value = 32'h77;
        issue(2'd0, 5'd8, 32'h110, 0, 1, 32'h1);
        wb1_valid = 0;
        check("br_flush", 32'(flush), 1);
        check("br_flush_pc", flush_pc, 32'h180);
        check("br_commit_valid", 32'(commit_valid), 1);
        check("br_commit_rd", 32'(commit_rd), 0);
        check("br_commit_store", 32'(commit_store), 0);
        check("br_count_zero", 32'(count), 0);
        check("br_empty", 32'(empty), 1);
        check("br_issue_id", 32'(issue_id), 0);
        tick();
        check("br_flush_pulse_end", 32'(flush), 0);
        check("br_no_commit_after", 32'(commit_valid), 0);
        check("br_still_empty", 32'(count), 0);

        // ---------------- Correct prediction and JALR ----------------
        do_reset();
        issue(2'd1, 5'd0, 32'h140, 1, 0, 0);
        issue(2'd3, 5'd9, 32'h200, 0, 0, 32'h204);
        wb0(0, 32'h0, 1, 32'h1C0);
        wb0(1, 32'h204, 0, 32'h300);
        check("bok_commit_valid", 32'(commit_valid), 1);
        check("bok_commit_id", 32'(commit_id), 0);
        check("bok_no_flush", 32'(flush), 0);
        check("bok_count", 32'(count), 1);
        tick();
        check("jalr_commit_valid", 32'(commit_valid), 1);
        check("jalr_commit_id", 32'(commit_id), 1);
        check("jalr_commit_rd", 32'(commit_rd), 9);
        check("jalr_commit_value", commit_value, 32'h204);
        check("jalr_flush", 32'(flush), 1);
        check("jalr_flush_pc", flush_pc, 32'h300);
        check("jalr_empty", 32'(empty), 1);

        // ---------------- STORE commit ----------------
        do_reset();
        issue(2'd2, 5'd12, 32'h400, 0, 1, 32'h0);
        tick();
        check("st_commit_valid", 32'(commit_valid), 1);
        check("st_commit_store", 32'(commit_store), 1);
        check("st_commit_rd", 32'(commit_rd), 0);
        check("st_no_flush", 32'(flush), 0);

        // ---------------- Query / bypass ----------------
        do_reset();
        for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 32'(i * 4), 0, 0, 0);
        // Entry 0 must not be ready, else it would commit; query ids 3 and 2.
        q1_id = 3; q2_id = 2;
        wb0_valid = 1; wb0_id = 3; wb0_value = 32'hDEAD;
        #1;
`ifdef ROB_WB_BYPASS_EN
        check("q_same_cycle_ready", 32'(q1_ready), 1);
        check("q_same_cycle_value", q1_value, 32'hDEAD);
`else
        check("q_same_cycle_ready", 32'(q1_ready), 0);
        check("q_same_cycle_value", q1_value, 0);
`endif
        check("q2_not_ready", 32'(q2_ready), 0);
        tick();
        wb0_valid = 0;
        #1;
        check("q_next_ready", 32'(q1_ready), 1);
        check("q_next_value", q1_value, 32'hDEAD);
        q1_id = 5;
        #1;
        check("q_nonbusy_ready", 32'(q1_ready), 0);

        // ---------------- rdy stall ----------------
        do_reset();
        issue(2'd0, 5'd3, 32'h0, 0, 0, 0);
        issue(2'd0, 5'd4, 32'h4, 0, 0, 0);
        wb0(0, 32'h77, 0, 0);
        rdy = 0;
        issue_valid = 1; issue_kind = 0; issue_rd = 5'd6;
        wb0_valid = 1; wb0_id = 1; wb0_value = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_count", i), 32'(count), 2);
            check($sformatf("stall%0d_commit", i), 32'(commit_valid), 0);
            check($sformatf("stall%0d_tail", i), 32'(issue_id), 2);
        end
        rdy = 1;
        idle_inputs();
        tick();
        check("stall_commit_valid", 32'(commit_valid), 1);
        check("stall_commit_id", 32'(commit_id), 0);
        check("stall_commit_value", commit_value, 32'h77);
        check("stall_count_after", 32'(count), 1);
        tick();
        check("stall_commit_once", 32'(commit_valid), 0);
        check("stall_count_hold", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
